// File: rtl/key_pkg.sv
// Shared definitions for the key pulse array: channel FSM state encoding and
// counter-width helper used to size the debounce and hold counters.
package key_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE       = 2'd0;
  localparam state_t PRESS_DB   = 2'd1;
  localparam state_t HELD       = 2'd2;
  localparam state_t RELEASE_DB = 2'd3;

  // Bits needed to hold the value max_val itself (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_pulse_array_if.sv
// Bundle of key inputs, clear strobes and the debounced/strobe/count outputs.
// master = control side driving keys, slave = the key pulse array itself.
interface key_pulse_array_if #(
  parameter int N_KEYS = 4,
  parameter int CNT_W  = 4
);

  logic [N_KEYS-1:0]       key_in;
  logic [N_KEYS-1:0]       cnt_clr;
  logic [N_KEYS-1:0]       held;
  logic [N_KEYS-1:0]       press_pulse;
  logic [N_KEYS-1:0]       release_pulse;
  logic [N_KEYS-1:0]       long_pulse;
  logic [N_KEYS*CNT_W-1:0] sum;

  modport master (
    output key_in, cnt_clr,
    input  held, press_pulse, release_pulse, long_pulse, sum
  );

  modport slave (
    input  key_in, cnt_clr,
    output held, press_pulse, release_pulse, long_pulse, sum
  );

endinterface

// File: rtl/key_pulse_ch.sv
// One key channel: 2-flop synchroniser, press/release debounce FSM with
// long-press detection, and a wrapping press counter with clear.
module key_pulse_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int LONG_CYCLES     = 500,
  parameter int CNT_W           = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_raw,
  input  logic             cnt_clr,
  output logic             held,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] cnt
);

  localparam int DCNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int HCNT_W = cnt_width(LONG_CYCLES);

  localparam logic              REL_LEVEL = ACTIVE_LOW;
  localparam logic [DCNT_W-1:0] D_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] H_MAX     = HCNT_W'(LONG_CYCLES);
  localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(LONG_CYCLES - 1);

  logic [1:0]        sync;
  logic              p;
  state_t            state;
  logic [DCNT_W-1:0] dcnt;
  logic [HCNT_W-1:0] hcnt;

  // Normalised level: 1 means pressed regardless of board polarity.
  assign p = sync[1] ^ REL_LEVEL;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= {2{REL_LEVEL}};
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      cnt           <= '0;
    end else begin
      sync <= {sync[0], key_raw};
      // NOTE: strobes default low with non-blocking assignments; a later
      // assignment in the same block overrides, giving exactly 1-cycle pulses.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_DB;
            dcnt  <= DCNT_W'(1);
          end
        end
        PRESS_DB: begin
          if (!p) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            dcnt        <= '0;
            hcnt        <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HELD: begin
          if (p) begin
            // Saturating at H_MAX makes the long strobe fire once per press.
            if (hcnt != H_MAX) hcnt <= hcnt + 1'b1;
            if (hcnt == H_LAST) long_pulse <= 1'b1;
          end else begin
            state <= RELEASE_DB;
            dcnt  <= DCNT_W'(1);
          end
        end
        RELEASE_DB: begin
          if (p) begin
            state <= HELD;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            dcnt          <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear takes priority over a press landing in the same cycle.
      if (cnt_clr)          cnt <= '0;
      else if (press_pulse) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_pulse_array.sv
// N independent debounced key channels; outputs packed per channel bit and
// press counts packed at [i*CNT_W +: CNT_W].
module key_pulse_array #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int LONG_CYCLES     = 500,
  parameter int CNT_W           = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic              clk,
  input logic              rst,
  key_pulse_array_if.slave bus
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_pulse_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .key_raw      (bus.key_in[i]),
      .cnt_clr      (bus.cnt_clr[i]),
      .held         (bus.held[i]),
      .press_pulse  (bus.press_pulse[i]),
      .release_pulse(bus.release_pulse[i]),
      .long_pulse   (bus.long_pulse[i]),
      .cnt          (bus.sum[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_key_pulse_array.sv
// Directed bench: stimulus queues expected strobe events with their cycle,
// a negedge monitor pops and compares every strobe the array produces.
module tb_key_pulse_array;

  localparam int NK  = 4;
  localparam int DB  = 10;
  localparam int LC  = 50;
  localparam int CW  = 4;
  localparam int LAT = DB + 2;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  string kname[3] = '{"press", "release", "long"};

  key_pulse_array_if #(.N_KEYS(NK), .CNT_W(CW)) bus ();

  key_pulse_array #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .CNT_W          (CW),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int ch, input bit expect_it);
    bus.key_in[ch] = 1'b0;
    if (expect_it) push(cyc + LAT, K_PRESS, ch);
  endtask

  task automatic release_key(input int ch, input bit expect_it);
    bus.key_in[ch] = 1'b1;
    if (expect_it) push(cyc + LAT, K_RELEASE, ch);
  endtask

  function automatic int sum_of(input int ch);
    return int'(bus.sum[ch*CW +: CW]);
  endfunction

  // Monitor: every strobe bit seen must match the head of the expected queue.
  always @(negedge clk) begin
    logic [NK-1:0] v;
    ev_t e;
    for (int k = 0; k < 3; k++) begin
      v = (k == K_PRESS) ? bus.press_pulse : (k == K_RELEASE) ? bus.release_pulse : bus.long_pulse;
      for (int c = 0; c < NK; c++) begin
        if (v[c] === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s ch%0d at cycle %0d, expected none", kname[k], c, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.ch != c) begin
              n_fail++;
              $display("FAIL event: got %s ch%0d at cycle %0d, expected %s ch%0d at cycle %0d",
                       kname[k], c, cyc, kname[e.kind], e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.key_in  = '1;
    bus.cnt_clr = '0;
    rst = 1'b1;
    tick(3);
    check("rst_held", bus.held, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_press", bus.press_pulse, 0);
    check("rst_release", bus.release_pulse, 0);
    check("rst_long", bus.long_pulse, 0);
    rst = 1'b0;
    tick(2);

    // Clean press / release on ch0.
    press(0, 1'b1);
    tick(13);
    check("t1_held", bus.held[0], 1);
    check("t1_sum", sum_of(0), 1);
    tick(10);
    release_key(0, 1'b1);
    tick(14);
    check("t1_released", bus.held[0], 0);

    // Bounce rejection on ch1: three 9-cycle lows, then one 10-cycle low.
    for (int i = 0; i < 3; i++) begin
      press(1, 1'b0);
      tick(9);
      release_key(1, 1'b0);
      tick(5);
    end
    check("t2_bounce_sum", sum_of(1), 0);
    check("t2_bounce_held", bus.held[1], 0);
    press(1, 1'b1);
    tick(10);
    release_key(1, 1'b1);
    tick(14);
    check("t2_sum", sum_of(1), 1);

    // Long press on ch2.
    press(2, 1'b1);
    push(cyc + LAT + LC, K_LONG, 2);
    tick(200);
    release_key(2, 1'b1);
    tick(15);
    check("t3_sum", sum_of(2), 1);
    check("t3_held", bus.held[2], 0);

    // Wrap on ch3, then clear colliding with a press strobe.
    for (int i = 0; i < 17; i++) begin
      press(3, 1'b1);
      tick(15);
      release_key(3, 1'b1);
      tick(15);
      if (i == 15) check("t4_wrap16", sum_of(3), 0);
    end
    check("t4_wrap17", sum_of(3), 1);
    press(3, 1'b1);
    tick(LAT);
    bus.cnt_clr[3] = 1'b1;
    tick(1);
    bus.cnt_clr[3] = 1'b0;
    tick(2);
    check("t4_clr_wins", sum_of(3), 0);
    check("t4_held_kept", bus.held[3], 1);
    release_key(3, 1'b1);
    tick(15);

    // Simultaneous presses after clearing every counter.
    bus.cnt_clr = '1;
    tick(1);
    bus.cnt_clr = '0;
    tick(1);
    check("t5_clr_all", bus.sum, 0);
    for (int c = 0; c < NK; c++) press(c, 1'b1);
    tick(15);
    for (int c = 0; c < NK; c++) check($sformatf("t5_sum%0d", c), sum_of(c), 1);
    check("t5_held", bus.held, 4'hF);
    release_key(0, 1'b0);
    tick(5);
    press(0, 1'b0);
    tick(20);
    check("t5_bounce_held", bus.held[0], 1);
    check("t5_bounce_sum", sum_of(0), 1);
    for (int c = 0; c < NK; c++) release_key(c, 1'b1);
    tick(15);
    check("t5_released", bus.held, 0);

    // Reset in the middle of a press debounce on ch0.
    press(0, 1'b0);
    tick(5);
    rst = 1'b1;
    tick(1);
    check("t6_rst_held", bus.held, 0);
    check("t6_rst_sum", bus.sum, 0);
    rst = 1'b0;
    push(cyc + LAT, K_PRESS, 0);
    tick(15);
    check("t6_held", bus.held[0], 1);
    check("t6_sum", sum_of(0), 1);
    release_key(0, 1'b1);
    tick(15);
    check("t6_released", bus.held[0], 0);

    tick(5);
    check("missed_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
